uart_cmd_sequencer: RTL and testbench

Parametrised UART command-frame generator. Holds a writable table of NUM_CMDS command frames, each BUF_BYTES bytes. It presents one frame at a time on cmd_buf and handshakes each frame into the UART transmitter with a start/busy/done protocol. Frames are separated by a programmable gap, and the table can be sent once or looped. It sits between host/config logic and the UART TX, and replaces fixed always-on command stimulus.

---
 rtl/uart_cmd_pkg.sv | 33 +++
 rtl/uart_cmd_table.sv | 50 +++++
 rtl/uart_cmd_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types for the UART command-frame sequencer.
//   seq_state_t        : sequencer FSM states
//   cmd_frame_t        : one command frame at the default frame size
//   CMD_FRAME_DEFAULT  : value of an empty (reset) frame
//   active_count()     : clamps the requested entry count into 1..max_n
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    localparam int CMD_BUF_BYTES_DEF = 12;
    localparam int CMD_NUM_DEF       = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        GAP  = 3'd4,
        DONE = 3'd5
    } seq_state_t;

    typedef logic [CMD_BUF_BYTES_DEF-1:0][7:0] cmd_frame_t;

    localparam cmd_frame_t CMD_FRAME_DEFAULT = '0;

    // A request of 0 entries, or more than the table holds, means "all of them".
    function automatic int unsigned active_count(input int unsigned num,
                                                 input int unsigned max_n);
        return ((num == 0) || (num > max_n)) ? max_n : num;
    endfunction

endpackage

// File: rtl/uart_cmd_table.sv
// -----------------------------------------------------------------------------
// uart_cmd_table
// Byte-writable table of NUM_CMDS command frames with one full-frame read port.
// Cleared to zero on reset. Writes with an out-of-range entry or byte index are
// dropped.
//   clk, rst_n   : clock, async active-low reset
//   we_i         : byte write strobe
//   wr_idx_i     : entry to write
//   wr_sel_i     : byte within entry
//   wr_data_i    : byte value
//   rd_idx_i     : entry presented on rd_frame_o (combinational read)
//   rd_frame_o   : full frame of entry rd_idx_i
// -----------------------------------------------------------------------------
module uart_cmd_table
    import uart_cmd_pkg::*;
#(
    parameter int BUF_BYTES = CMD_BUF_BYTES_DEF,
    parameter int NUM_CMDS  = CMD_NUM_DEF,
    parameter int IDX_W     = 2,
    parameter int SEL_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic [IDX_W-1:0]          wr_idx_i,
    input  logic [SEL_W-1:0]          wr_sel_i,
    input  logic [7:0]                wr_data_i,
    input  logic [IDX_W-1:0]          rd_idx_i,
    output logic [BUF_BYTES-1:0][7:0] rd_frame_o
);

    logic [BUF_BYTES-1:0][7:0] mem_q [NUM_CMDS];
    logic                      wr_ok;

    assign wr_ok = (32'(wr_idx_i) < NUM_CMDS) && (32'(wr_sel_i) < BUF_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CMDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && wr_ok) begin
            mem_q[wr_idx_i][wr_sel_i] <= wr_data_i;
        end
    end

    // Guard keeps a non-power-of-two table from reading past its last entry.
    assign rd_frame_o = (32'(rd_idx_i) < NUM_CMDS) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// uart_cmd_sequencer
// Steps through a table of command frames and hands each one to the UART
// transmitter with a start/busy/done handshake, with a programmable idle gap
// between frames. The table can be sent once or looped.
//
// Ports
//   clk, rst_n                 : clock, async active-low reset
//   cfg_we/cfg_idx/
//   cfg_byte_sel/cfg_data      : table byte write port (usable in any state)
//   num_cmds                   : active entries (0 or too large = all)
//   gap_cycles                 : idle cycles between frames
//   loop_en                    : wrap to entry 0 after the last active entry
//   go                         : start request, sampled in IDLE/DONE
//   abort                      : stop request (never truncates a frame on air)
//   uart_busy, uart_done       : transmitter accept / frame-complete
//   uart_start                 : frame-valid request to the transmitter
//   cmd_buf                    : frame being sent
//   cur_idx                    : table entry of cmd_buf
//   seq_busy, seq_done         : status
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; waiting for go
// LOAD  | copy table[idx] into cmd_buf (one cycle)
// REQ   | uart_start high until the transmitter shows busy
// WAIT  | frame on air; waiting for uart_done
// GAP   | counting inter-frame idle cycles, then pick next entry
// DONE  | table sent once; seq_done high; waiting for go
// -----------------------------------------------------------------------------
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int  BUF_BYTES = CMD_BUF_BYTES_DEF,
    parameter int  NUM_CMDS  = CMD_NUM_DEF,
    parameter int  GAP_W     = 16,
    localparam int IDX_W     = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1,
    localparam int SEL_W     = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic [SEL_W-1:0]          cfg_byte_sel,
    input  logic [7:0]                cfg_data,
    input  logic [IDX_W:0]            num_cmds,
    input  logic [GAP_W-1:0]          gap_cycles,
    input  logic                      loop_en,
    input  logic                      go,
    input  logic                      abort,
    input  logic                      uart_busy,
    input  logic                      uart_done,
    output logic                      uart_start,
    output logic [BUF_BYTES-1:0][7:0] cmd_buf,
    output logic [IDX_W-1:0]          cur_idx,
    output logic                      seq_busy,
    output logic                      seq_done
);

    typedef logic [BUF_BYTES-1:0][7:0] frame_t;

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    frame_t           cmd_buf_q, cmd_buf_d;
    logic             uart_start_q, uart_start_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             abort_pend_q, abort_pend_d;

    frame_t           tbl_frame;

    int unsigned      act_cnt;
    logic             last_entry;
    logic [IDX_W-1:0] adv_idx;
    seq_state_t       adv_state;
    seq_state_t       end_state;
    logic [IDX_W-1:0] end_idx;
    logic [GAP_W-1:0] end_gap;

    uart_cmd_table #(
        .BUF_BYTES (BUF_BYTES),
        .NUM_CMDS  (NUM_CMDS),
        .IDX_W     (IDX_W),
        .SEL_W     (SEL_W)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (cfg_we),
        .wr_idx_i   (cfg_idx),
        .wr_sel_i   (cfg_byte_sel),
        .wr_data_i  (cfg_data),
        .rd_idx_i   (idx_q),
        .rd_frame_o (tbl_frame)
    );

    // Next-entry decision and end-of-frame routing. With a zero gap the GAP
    // state is skipped entirely so uart_done -> uart_start stays at 2 cycles;
    // otherwise the counter is preloaded with gap-1 so GAP lasts exactly
    // gap_cycles cycles.
    always_comb begin
        act_cnt    = active_count(32'(num_cmds), NUM_CMDS);
        last_entry = ((32'(idx_q) + 32'd1) >= act_cnt);
        adv_idx    = last_entry ? '0 : (idx_q + IDX_W'(1));
        adv_state  = (last_entry && !loop_en) ? DONE : LOAD;
        if (gap_cycles == '0) begin
            end_state = adv_state;
            end_idx   = adv_idx;
            end_gap   = '0;
        end else begin
            end_state = GAP;
            end_idx   = idx_q;
            end_gap   = gap_cycles - GAP_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cur_idx_d    = cur_idx_q;
        cmd_buf_d    = cmd_buf_q;
        uart_start_d = uart_start_q;
        gap_d        = gap_q;
        abort_pend_d = abort_pend_q;

        case (state_q)
            IDLE, DONE: begin
                uart_start_d = 1'b0;
                abort_pend_d = 1'b0;
                if (!abort && go) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end

            LOAD: begin
                if (abort) begin
                    state_d      = IDLE;
                    uart_start_d = 1'b0;
                end else begin
                    cmd_buf_d    = tbl_frame;
                    cur_idx_d    = idx_q;
                    uart_start_d = 1'b1;
                    state_d      = REQ;
                end
            end

            REQ: begin
                if (abort) begin
                    state_d      = IDLE;
                    uart_start_d = 1'b0;
                end else if (uart_busy) begin
                    uart_start_d = 1'b0;
                    if (uart_done) begin
                        state_d = end_state;
                        idx_d   = end_idx;
                        gap_d   = end_gap;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            // An abort here is remembered and honoured once the frame is out.
            WAIT: begin
                abort_pend_d = abort_pend_q | abort;
                if (uart_done) begin
                    abort_pend_d = 1'b0;
                    if (abort_pend_q || abort) begin
                        state_d = IDLE;
                    end else begin
                        state_d = end_state;
                        idx_d   = end_idx;
                        gap_d   = end_gap;
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: begin
                state_d      = IDLE;
                uart_start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cur_idx_q    <= '0;
            cmd_buf_q    <= '0;
            uart_start_q <= 1'b0;
            gap_q        <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cur_idx_q    <= cur_idx_d;
            cmd_buf_q    <= cmd_buf_d;
            uart_start_q <= uart_start_d;
            gap_q        <= gap_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign uart_start = uart_start_q;
    assign cmd_buf    = cmd_buf_q;
    assign cur_idx    = cur_idx_q;
    assign seq_busy   = (state_q != IDLE) && (state_q != DONE);
    assign seq_done   = (state_q == DONE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
module tb_uart_cmd_sequencer;
    import uart_cmd_pkg::*;

    localparam int BUF_BYTES = 12;
    localparam int NUM_CMDS  = 4;
    localparam int GAP_W     = 16;
    localparam int IDX_W     = 2;
    localparam int SEL_W     = 4;

    logic                      clk;
    logic                      rst_n;
    logic                      cfg_we;
    logic [IDX_W-1:0]          cfg_idx;
    logic [SEL_W-1:0]          cfg_byte_sel;
    logic [7:0]                cfg_data;
    logic [IDX_W:0]            num_cmds;
    logic [GAP_W-1:0]          gap_cycles;
    logic                      loop_en;
    logic                      go;
    logic                      abort;
    logic                      uart_busy;
    logic                      uart_done;
    logic                      uart_start;
    logic [BUF_BYTES-1:0][7:0] cmd_buf;
    logic [IDX_W-1:0]          cur_idx;
    logic                      seq_busy;
    logic                      seq_done;

    uart_cmd_sequencer #(
        .BUF_BYTES (BUF_BYTES),
        .NUM_CMDS  (NUM_CMDS),
        .GAP_W     (GAP_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_byte_sel (cfg_byte_sel),
        .cfg_data     (cfg_data),
        .num_cmds     (num_cmds),
        .gap_cycles   (gap_cycles),
        .loop_en      (loop_en),
        .go           (go),
        .abort        (abort),
        .uart_busy    (uart_busy),
        .uart_done    (uart_done),
        .uart_start   (uart_start),
        .cmd_buf      (cmd_buf),
        .cur_idx      (cur_idx),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int num;
        bit loop;
        int gap;
        int dly;
        int frames;
        bit same;
        bit exp_done;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    cmd_frame_t shadow [NUM_CMDS];
    int         exp_q [$];
    vec_t       vecs [6];
    vec_t       rst_vec;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr_byte(input int idx, input int sel, input logic [7:0] d);
        cfg_we       = 1'b1;
        cfg_idx      = IDX_W'(idx);
        cfg_byte_sel = SEL_W'(sel);
        cfg_data     = d;
        tick();
        cfg_we = 1'b0;
        if (idx < NUM_CMDS && sel < BUF_BYTES) shadow[idx][sel] = d;
    endtask

    task automatic pop_compare(input string name);
        int e;
        if (exp_q.size() == 0) begin
            check_eq({name, " unexpected frame"}, 128'(1), 128'(0));
        end else begin
            e = exp_q.pop_front();
            check_eq({name, " cur_idx"}, 128'(cur_idx), 128'(e));
            check_eq({name, " cmd_buf"}, 128'(cmd_buf), 128'(shadow[e]));
        end
    endtask

    // Ticks until uart_start is seen; pulse inputs are released after the
    // first edge. Latency is counted from the cycle the pulse was driven.
    task automatic wait_start(input string name, input int exp_lat);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            tick();
            n++;
            go        = 1'b0;
            uart_done = 1'b0;
            uart_busy = 1'b0;
            if (uart_start === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            check_eq({name, " start timeout"}, 128'(0), 128'(1));
        end else begin
            check_eq({name, " latency"}, 128'(n), 128'(exp_lat));
            pop_compare(name);
        end
    endtask

    task automatic idle_quiet(input string name, input int n);
        bit ok;
        ok = 1'b1;
        repeat (n) begin
            tick();
            if (uart_start !== 1'b0) ok = 1'b0;
        end
        check_eq({name, " no start"}, 128'(ok), 128'(1));
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int act;
        int lat;
        bit hold_ok;
        logic [BUF_BYTES-1:0][7:0] snap;
        string nm;
        num_cmds   = 3'(v.num);
        gap_cycles = 16'(v.gap);
        loop_en    = v.loop;
        act = (v.num == 0 || v.num > NUM_CMDS) ? NUM_CMDS : v.num;
        for (int k = 0; k < v.frames; k++) exp_q.push_back(k % act);
        go  = 1'b1;
        lat = 2;
        for (int k = 0; k < v.frames; k++) begin
            nm = $sformatf("v%0d f%0d", vi, k);
            wait_start(nm, lat);
            if (v.dly > 0) begin
                snap    = cmd_buf;
                hold_ok = 1'b1;
                repeat (v.dly) begin
                    tick();
                    if (uart_start !== 1'b1 || cmd_buf !== snap) hold_ok = 1'b0;
                end
                check_eq({nm, " backpressure hold"}, 128'(hold_ok), 128'(1));
            end
            if (v.same) begin
                uart_busy = 1'b1;
                uart_done = 1'b1;
            end else begin
                uart_busy = 1'b1;
                tick();
                check_eq({nm, " start drop"}, 128'(uart_start), 128'(0));
                tick();
                tick();
                uart_done = 1'b1;
            end
            lat = v.gap + 2;
        end
        tick();
        uart_done = 1'b0;
        uart_busy = 1'b0;
        if (v.exp_done) begin
            repeat (v.gap) tick();
            check_eq($sformatf("v%0d seq_done", vi), 128'(seq_done), 128'(1));
            check_eq($sformatf("v%0d seq_busy", vi), 128'(seq_busy), 128'(0));
        end else begin
            tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_eq($sformatf("v%0d gap abort busy", vi), 128'(seq_busy), 128'(0));
            check_eq($sformatf("v%0d gap abort done", vi), 128'(seq_done), 128'(0));
            idle_quiet($sformatf("v%0d after abort", vi), 10);
        end
        check_eq($sformatf("v%0d sb drained", vi), 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            num loop gap dly frames same done
        vecs[0] = '{1,   0,   0,  0,  1,     0,   1};
        vecs[1] = '{3,   0,   2,  50, 3,     0,   1};
        vecs[2] = '{0,   0,   1,  2,  4,     0,   1};
        vecs[3] = '{5,   0,   0,  1,  4,     1,   1};
        vecs[4] = '{3,   1,   5,  0,  5,     0,   0};
        vecs[5] = '{2,   0,   3,  0,  2,     1,   1};
        rst_vec = '{0,   0,   0,  0,  4,     0,   1};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_byte_sel = '0; cfg_data = '0;
        num_cmds = '0; gap_cycles = '0; loop_en = 1'b0; go = 1'b0; abort = 1'b0;
        uart_busy = 1'b0; uart_done = 1'b0;
        for (int i = 0; i < NUM_CMDS; i++) shadow[i] = CMD_FRAME_DEFAULT;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check_eq("reset uart_start", 128'(uart_start), 128'(0));
        check_eq("reset cmd_buf", 128'(cmd_buf), 128'(0));
        check_eq("reset cur_idx", 128'(cur_idx), 128'(0));
        check_eq("reset seq_busy", 128'(seq_busy), 128'(0));
        check_eq("reset seq_done", 128'(seq_done), 128'(0));

        for (int e = 0; e < NUM_CMDS; e++) begin
            for (int b = 0; b < BUF_BYTES; b++) begin
                if (e == 0) wr_byte(e, b, (b == 0) ? 8'h14 : (b == 3) ? 8'h01 : (b == 4) ? 8'h98 : 8'h00);
                else        wr_byte(e, b, 8'($urandom_range(1, 255)));
            end
        end
        wr_byte(0, 13, 8'hEE);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // abort while entry 1 is on air
        num_cmds = 3'd3; gap_cycles = '0; loop_en = 1'b0;
        exp_q.push_back(0); exp_q.push_back(1);
        go = 1'b1;
        wait_start("aw f0", 2);
        uart_busy = 1'b1; tick(); tick();
        uart_done = 1'b1;
        wait_start("aw f1", 2);
        uart_busy = 1'b1; tick();
        abort = 1'b1; tick(); abort = 1'b0;
        repeat (3) tick();
        check_eq("aw still busy", 128'(seq_busy), 128'(1));
        check_eq("aw no start", 128'(uart_start), 128'(0));
        uart_done = 1'b1; tick(); uart_done = 1'b0; uart_busy = 1'b0;
        check_eq("aw idle busy", 128'(seq_busy), 128'(0));
        check_eq("aw idle done", 128'(seq_done), 128'(0));
        idle_quiet("aw", 10);

        // live rewrite of the entry being sent, then abort in REQ
        num_cmds = 3'd2; gap_cycles = '0; loop_en = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        go = 1'b1;
        wait_start("lw f0", 2);
        check_eq("lw byte0", 128'(cmd_buf[0]), 128'(8'h14));
        check_eq("lw byte4", 128'(cmd_buf[4]), 128'(8'h98));
        uart_busy = 1'b1; tick();
        wr_byte(0, 0, 8'hAA);
        tick();
        check_eq("lw byte0 held", 128'(cmd_buf[0]), 128'(8'h14));
        uart_done = 1'b1;
        wait_start("lw f1", 2);
        uart_busy = 1'b1; tick(); tick();
        uart_done = 1'b1;
        wait_start("lw f2", 2);
        check_eq("lw byte0 reloaded", 128'(cmd_buf[0]), 128'(8'hAA));
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("req abort start", 128'(uart_start), 128'(0));
        check_eq("req abort busy", 128'(seq_busy), 128'(0));
        idle_quiet("req abort", 8);

        // asynchronous reset while requesting
        num_cmds = 3'd1; gap_cycles = '0; loop_en = 1'b0;
        exp_q.push_back(0);
        go = 1'b1;
        wait_start("rst f0", 2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst uart_start", 128'(uart_start), 128'(0));
        check_eq("rst cmd_buf", 128'(cmd_buf), 128'(0));
        check_eq("rst cur_idx", 128'(cur_idx), 128'(0));
        check_eq("rst seq_busy", 128'(seq_busy), 128'(0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_CMDS; i++) shadow[i] = CMD_FRAME_DEFAULT;
        tick();
        run_vec(9, rst_vec);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
